// File: rtl/riscv_clint_pkg.sv
// Shared CLINT definitions: register offsets, FSM encodings and the offset decoder.
package riscv_clint_pkg;

  localparam logic [63:0] CLINT_BASE_DEFAULT = 64'h0000_0000_0200_0000;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } clint_reg_e;

  // Exact 16-bit match, so misaligned offsets fall through to REG_NONE.
  function automatic clint_reg_e decode_reg(input logic [15:0] off);
    clint_reg_e r;
    r = REG_NONE;
    case (off)
      CLINT_MSIP_OFF:     r = REG_MSIP;
      CLINT_MTIMECMP_OFF: r = REG_MTIMECMP;
      CLINT_MTIME_OFF:    r = REG_MTIME;
      default:            r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_clint_timer.sv
// mtime counter with a TICK_DIV prescaler; a load overrides any tick in the same cycle.
module riscv_clint_timer
  import riscv_clint_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_mtime
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] mtime_q, mtime_d;
  logic             tick;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = mtime_q;
    if (i_load_en) begin
      mtime_d = i_load_val;
    end else if (tick) begin
      mtime_d = mtime_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign o_mtime = mtime_q;

endmodule

// File: rtl/riscv_clint.sv
// RISC-V core-local interruptor: msip/mtimecmp/mtime behind a registered single-beat bus port.
module riscv_clint
  import riscv_clint_pkg::*;
#(
  parameter int unsigned DBUS_DATA_WIDTH = 64,
  parameter int unsigned DMEM_ADDR_WIDTH = 64,
  parameter logic [63:0] CLINT_BASE      = CLINT_BASE_DEFAULT,
  parameter int unsigned TICK_DIV        = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic                       i_rd_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] i_addr,
  input  logic [DBUS_DATA_WIDTH-1:0] i_wdata,
  output logic [DBUS_DATA_WIDTH-1:0] o_rdata,
  output logic                       o_rdata_valid,
  output logic                       o_wr_ready,
  output logic                       o_timer_irq,
  output logic                       o_soft_irq
);

  localparam int unsigned W = DBUS_DATA_WIDTH;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;
  logic         wready_q, wready_d;
  logic         msip_q, msip_d;
  logic [W-1:0] mtimecmp_q, mtimecmp_d;
  logic         tirq_q, tirq_d;

  logic [15:0]  offset;
  clint_reg_e   sel;
  logic         accept;
  logic [W-1:0] rd_val;
  logic [W-1:0] mtime;
  logic         mtime_load;
  logic         unused_addr;

  assign unused_addr = ^i_addr[DMEM_ADDR_WIDTH-1:16];

  assign offset = i_addr[15:0] - CLINT_BASE[15:0];
  assign sel    = decode_reg(offset);
  assign accept = (state_q == ST_IDLE) && (i_rd_en || i_wr_en);

  riscv_clint_timer #(
    .WIDTH    (W),
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load_en  (mtime_load),
    .i_load_val (i_wdata),
    .o_mtime    (mtime)
  );

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_MSIP:     rd_val = {{(W-1){1'b0}}, msip_q};
      REG_MTIMECMP: rd_val = mtimecmp_q;
      REG_MTIME:    rd_val = mtime;
      default:      rd_val = '0;
    endcase
  end

  // Read data is taken from the current register values, so a combined
  // read+write at one address returns the pre-write contents.
  always_comb begin
    state_d    = accept ? ST_RESP : ST_IDLE;
    rdata_d    = (accept && i_rd_en) ? rd_val : rdata_q;
    rvalid_d   = accept && i_rd_en;
    wready_d   = accept && i_wr_en;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_load = 1'b0;
    if (accept && i_wr_en) begin
      case (sel)
        REG_MSIP:     msip_d     = i_wdata[0];
        REG_MTIMECMP: mtimecmp_d = i_wdata;
        REG_MTIME:    mtime_load = 1'b1;
        default:      ;
      endcase
    end
    tirq_d = (mtime >= mtimecmp_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      wready_q   <= 1'b0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      tirq_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      wready_q   <= wready_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      tirq_q     <= tirq_d;
    end
  end

  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rvalid_q;
  assign o_wr_ready    = wready_q;
  assign o_timer_irq   = tirq_q;
  assign o_soft_irq    = msip_q;

endmodule

// File: tb/tb_riscv_clint.sv
// Self-checking bench for riscv_clint against a cycle-count based CLINT model.
module tb_riscv_clint;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] o_rdata;
  logic        o_rdata_valid, o_wr_ready, o_timer_irq, o_soft_irq;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_clint #(
    .DBUS_DATA_WIDTH (64),
    .DMEM_ADDR_WIDTH (64),
    .CLINT_BASE      (64'h0000_0000_0200_0000),
    .TICK_DIV        (1)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wr_en       (wr_en),
    .i_rd_en       (rd_en),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_rdata       (o_rdata),
    .o_rdata_valid (o_rdata_valid),
    .o_wr_ready    (o_wr_ready),
    .o_timer_irq   (o_timer_irq),
    .o_soft_irq    (o_soft_irq)
  );

  // Model: mtime is base value plus edges elapsed since it was set (TICK_DIV = 1).
  logic [63:0] m_base, m_cmp;
  int unsigned m_base_cyc;
  logic        m_msip;

  logic [63:0] exp_rdata, got_rdata;
  logic        got_rv, got_wr, post_rv, post_wr;

  function automatic logic [63:0] m_time(input int unsigned k);
    return m_base + 64'(k - m_base_cyc);
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a, input int unsigned k);
    logic [63:0] off;
    off = a - BASE;
    if (off == 64'h0)         return {63'b0, m_msip};
    else if (off == 64'h4000) return m_cmp;
    else if (off == 64'hBFF8) return m_time(k);
    else                      return 64'h0;
  endfunction

  function automatic logic exp_tirq();
    return m_time(cyc - 1) >= m_cmp;
  endfunction

  task automatic m_reset();
    m_base = '0;
    m_base_cyc = cyc;
    m_cmp = '1;
    m_msip = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response cycle.
  task automatic xact(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] off;
    exp_rdata = m_read(a, cyc);
    rd_en = rd; wr_en = wr; addr = a; wdata = wd;
    if (wr) begin
      off = a - BASE;
      if (off == 64'h0) m_msip = wd[0];
      else if (off == 64'h4000) m_cmp = wd;
      else if (off == 64'hBFF8) begin
        m_base = wd;
        m_base_cyc = cyc + 1;
      end
    end
    @(negedge clk);
    got_rdata = o_rdata; got_rv = o_rdata_valid; got_wr = o_wr_ready;
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    post_rv = o_rdata_valid; post_wr = o_wr_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (o_rdata !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", o_rdata); else n_pass++;
    n_total++; if (o_rdata_valid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", o_rdata_valid); else n_pass++;
    n_total++; if (o_wr_ready !== 1'b0) $display("FAIL reset_wready got=%b exp=0", o_wr_ready); else n_pass++;
    n_total++; if (o_timer_irq !== 1'b0) $display("FAIL reset_tirq got=%b exp=0", o_timer_irq); else n_pass++;
    n_total++; if (o_soft_irq !== 1'b0) $display("FAIL reset_sirq got=%b exp=0", o_soft_irq); else n_pass++;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_mtime_idle();
    repeat (10) @(negedge clk);
    xact(1'b1, 1'b0, A_TIME, '0);
    n_total++; if (got_rv !== 1'b1) $display("FAIL idle_rvalid got=%b exp=1", got_rv); else n_pass++;
    n_total++; if (got_rdata !== exp_rdata) $display("FAIL idle_mtime got=%h exp=%h", got_rdata, exp_rdata); else n_pass++;
    n_total++; if (o_timer_irq !== 1'b0) $display("FAIL idle_tirq got=%b exp=0", o_timer_irq); else n_pass++;
  endtask

  task automatic test_timer_irq();
    xact(1'b0, 1'b1, A_TIME, 64'h0);
    xact(1'b0, 1'b1, A_CMP, 64'h20);
    for (int i = 0; i < 200 && m_time(cyc) != 64'h20; i++) @(negedge clk);
    n_total++; if (o_timer_irq !== 1'b0) $display("FAIL tirq_before got=%b exp=0", o_timer_irq); else n_pass++;
    @(negedge clk);
    n_total++; if (o_timer_irq !== 1'b1) $display("FAIL tirq_rise got=%b exp=1", o_timer_irq); else n_pass++;
    xact(1'b0, 1'b1, A_CMP, '1);
    n_total++; if (got_wr !== 1'b1) $display("FAIL cmp_wready got=%b exp=1", got_wr); else n_pass++;
    n_total++; if (o_timer_irq !== 1'b0) $display("FAIL tirq_fall got=%b exp=0", o_timer_irq); else n_pass++;
  endtask

  task automatic test_soft_irq();
    xact(1'b0, 1'b1, A_MSIP, 64'hFFFF_FFFF);
    n_total++; if (o_soft_irq !== 1'b1) $display("FAIL sirq_set got=%b exp=1", o_soft_irq); else n_pass++;
    xact(1'b1, 1'b0, A_MSIP, '0);
    n_total++; if (got_rdata !== 64'h1) $display("FAIL msip_read got=%h exp=1", got_rdata); else n_pass++;
    xact(1'b0, 1'b1, A_MSIP, 64'h0);
    n_total++; if (o_soft_irq !== 1'b0) $display("FAIL sirq_clr got=%b exp=0", o_soft_irq); else n_pass++;
  endtask

  task automatic test_hold_read();
    int unsigned pulses;
    logic exp_v;
    pulses = 0;
    rd_en = 1'b1; addr = A_CMP;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = (i % 2 == 0);
      if (o_rdata_valid === 1'b1) pulses++;
      n_total++; if (o_rdata_valid !== exp_v) $display("FAIL hold_rvalid_%0d got=%b exp=%b", i, o_rdata_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++; if (o_rdata !== m_cmp) $display("FAIL hold_rdata_%0d got=%h exp=%h", i, o_rdata, m_cmp); else n_pass++;
      end
    end
    rd_en = 1'b0;
    n_total++; if (pulses != 2) $display("FAIL hold_pulses got=%0d exp=2", pulses); else n_pass++;
    xact(1'b1, 1'b0, BASE + 64'h1000, '0);
    n_total++; if (got_rv !== 1'b1 || got_rdata !== 64'h0) $display("FAIL unmapped_read got=%h/%b exp=0/1", got_rdata, got_rv); else n_pass++;
  endtask

  task automatic test_mtime_wrap();
    xact(1'b0, 1'b1, A_TIME, '1);
    xact(1'b1, 1'b0, A_TIME, '0);
    n_total++; if (got_rdata !== exp_rdata || got_rdata !== 64'h0) $display("FAIL mtime_wrap got=%h exp=%h", got_rdata, exp_rdata); else n_pass++;
    xact(1'b0, 1'b1, A_TIME, 64'h1234_5678);
    xact(1'b1, 1'b0, A_TIME, '0);
    n_total++; if (got_rdata !== exp_rdata) $display("FAIL mtime_load_tick got=%h exp=%h", got_rdata, exp_rdata); else n_pass++;
  endtask

  task automatic test_rw_same();
    logic [63:0] c1, c2;
    c1 = {$urandom, $urandom};
    c2 = {$urandom, $urandom};
    xact(1'b0, 1'b1, A_CMP, c1);
    xact(1'b1, 1'b1, A_CMP, c2);
    n_total++; if (got_rdata !== c1) $display("FAIL rw_old_data got=%h exp=%h", got_rdata, c1); else n_pass++;
    n_total++; if (got_rv !== 1'b1 || got_wr !== 1'b1) $display("FAIL rw_pulses got=%b%b exp=11", got_rv, got_wr); else n_pass++;
    n_total++; if (post_rv !== 1'b0 || post_wr !== 1'b0) $display("FAIL rw_pulse_len got=%b%b exp=00", post_rv, post_wr); else n_pass++;
    xact(1'b1, 1'b0, A_CMP, '0);
    n_total++; if (got_rdata !== c2) $display("FAIL rw_new_data got=%h exp=%h", got_rdata, c2); else n_pass++;
  endtask

  task automatic test_reset_mid();
    xact(1'b0, 1'b1, A_CMP, 64'h5);
    xact(1'b0, 1'b1, A_MSIP, 64'h1);
    rd_en = 1'b1; addr = A_CMP;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    n_total++; if (o_rdata_valid !== 1'b0) $display("FAIL abort_rvalid got=%b exp=0", o_rdata_valid); else n_pass++;
    n_total++; if (o_soft_irq !== 1'b0) $display("FAIL abort_sirq got=%b exp=0", o_soft_irq); else n_pass++;
    @(negedge clk);
    n_total++; if (o_rdata_valid !== 1'b0) $display("FAIL abort_rvalid_late got=%b exp=0", o_rdata_valid); else n_pass++;
    rst_n = 1'b1;
    m_reset();
    xact(1'b1, 1'b0, A_CMP, '0);
    n_total++; if (got_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL abort_cmp got=%h exp=all-ones", got_rdata); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned kind;
    logic rd, wr;
    logic [63:0] a, wd;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 5);
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      wd = {$urandom, $urandom};
      case (kind)
        0: a = A_MSIP;
        1: a = A_CMP;
        2: a = A_TIME;
        3: a = BASE + 64'({$urandom_range(0, 16'h1FFF), 3'b000});
        4: a = A_CMP + 64'($urandom_range(1, 7));
        default: begin
          a = A_CMP;
          wd = m_time(cyc) + 64'($urandom_range(0, 8)) - 64'd4;
        end
      endcase
      xact(rd, wr, a, wd);
      if (rd) begin
        n_total++; if (got_rv !== 1'b1 || got_rdata !== exp_rdata) $display("FAIL rand_read_%0d got=%h/%b exp=%h/1", i, got_rdata, got_rv, exp_rdata); else n_pass++;
      end
      n_total++; if (got_wr !== wr || post_rv !== 1'b0) $display("FAIL rand_pulses_%0d got=%b%b exp=%b0", i, got_wr, post_rv, wr); else n_pass++;
      n_total++; if (o_timer_irq !== exp_tirq()) $display("FAIL rand_tirq_%0d got=%b exp=%b", i, o_timer_irq, exp_tirq()); else n_pass++;
      n_total++; if (o_soft_irq !== m_msip) $display("FAIL rand_sirq_%0d got=%b exp=%b", i, o_soft_irq, m_msip); else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mtime_idle();
    test_timer_irq();
    test_soft_irq();
    test_hold_read();
    test_mtime_wrap();
    test_rw_same();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
